// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and constants for the round-robin / fixed-priority lock arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index successor with wrap at n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between N sources, the arbiter and one downstream channel.
interface rr_lock_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_IN    = 4
);
  localparam int IDX_W = $clog2(NUM_IN);

  logic [NUM_IN*DATA_SIZE-1:0] in_data;
  logic [NUM_IN-1:0]           in_valid;
  logic                        out_grant;
  logic [DATA_SIZE-1:0]        out_data;
  logic                        out_valid;
  logic [NUM_IN-1:0]           in_grant;
  logic [IDX_W-1:0]            sel;
  logic                        locked;

  modport slave (
    input  in_data, in_valid, out_grant,
    output out_data, out_valid, in_grant, sel, locked
  );

  modport master (
    output in_data, in_valid, out_grant,
    input  out_data, out_valid, in_grant, sel, locked
  );

endinterface

// File: rtl/rr_lock_arbiter_rr_pick.sv
// Masked priority encoder: lowest request at or above i_ptr, else lowest overall.
module rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_hi_mask;
  logic [N-1:0] w_hi_req;

  function automatic logic [IDX_W-1:0] lowest(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign w_hi_mask = ~((N'(1) << i_ptr) - N'(1));
  assign w_hi_req  = i_req & w_hi_mask;
  assign o_any     = |i_req;

  // With nothing requested the pointer itself is reported as the index.
  always_comb begin
    o_idx = i_ptr;
    if (|w_hi_req)   o_idx = lowest(w_hi_req);
    else if (|i_req) o_idx = lowest(i_req);
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-input arbiter that holds the presented source until the output handshake completes.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int NUM_IN    = 4,
  parameter int RR_MODE   = ARB_RR
) (
  input logic              AXI_CLK_i,
  input logic              AXI_RSTn_i,
  rr_lock_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_IN);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_lock_idx;
  logic [IDX_W-1:0]  w_lock_idx_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  w_rr_ptr_nxt;
  logic [IDX_W-1:0]  w_ptr;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_win_any;
  logic [IDX_W-1:0]  w_sel;
  logic              w_out_valid;
  logic              w_hs;
  logic [NUM_IN-1:0] w_grant;

  assign w_ptr = (RR_MODE == ARB_FIXED) ? '0 : r_rr_ptr;

  rr_pick #(.N(NUM_IN)) u_pick (
    .i_req (bus.in_valid),
    .i_ptr (w_ptr),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // Reset forces index 0 and no valid regardless of the stored state.
  always_comb begin
    w_sel       = '0;
    w_out_valid = 1'b0;
    if (AXI_RSTn_i) begin
      if (r_state == LOCKED) begin
        w_sel       = r_lock_idx;
        w_out_valid = bus.in_valid[r_lock_idx];
      end else begin
        w_sel       = w_win_idx;
        w_out_valid = w_win_any;
      end
    end
  end

  assign w_hs = w_out_valid && bus.out_grant;

  always_comb begin
    w_grant = '0;
    if (w_hs) w_grant[w_sel] = 1'b1;
  end

  assign bus.sel       = w_sel;
  assign bus.out_valid = w_out_valid;
  assign bus.in_grant  = w_grant;
  assign bus.out_data  = bus.in_data[w_sel*DATA_SIZE +: DATA_SIZE];
  assign bus.locked    = AXI_RSTn_i && (r_state == LOCKED);

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    w_rr_ptr_nxt   = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (RR_MODE == ARB_RR)
            w_rr_ptr_nxt = IDX_W'(wrap_inc(int'(w_win_idx), NUM_IN));
        end else if (w_out_valid) begin
          w_lock_idx_nxt = w_win_idx;
          w_state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        if (w_hs) begin
          w_state_nxt = IDLE;
          if (RR_MODE == ARB_RR)
            w_rr_ptr_nxt = IDX_W'(wrap_inc(int'(r_lock_idx), NUM_IN));
        end else if (!bus.in_valid[r_lock_idx]) begin
          // Requester withdrew: release without granting or moving the pointer.
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (!AXI_RSTn_i) begin
      r_state    <= IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: 4-input RR, 4-input fixed and 3-input RR instances on shared stimulus.
module tb_rr_lock_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  rr_lock_arbiter_if #(.DATA_SIZE(32), .NUM_IN(4)) bus4 ();
  rr_lock_arbiter_if #(.DATA_SIZE(32), .NUM_IN(4)) busf ();
  rr_lock_arbiter_if #(.DATA_SIZE(32), .NUM_IN(3)) bus3 ();

  rr_lock_arbiter #(.DATA_SIZE(32), .NUM_IN(4), .RR_MODE(1)) u_rr4 (
    .AXI_CLK_i(clk), .AXI_RSTn_i(rstn), .bus(bus4));
  rr_lock_arbiter #(.DATA_SIZE(32), .NUM_IN(4), .RR_MODE(0)) u_fix (
    .AXI_CLK_i(clk), .AXI_RSTn_i(rstn), .bus(busf));
  rr_lock_arbiter #(.DATA_SIZE(32), .NUM_IN(3), .RR_MODE(1)) u_rr3 (
    .AXI_CLK_i(clk), .AXI_RSTn_i(rstn), .bus(bus3));

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] d [4];
  bit          cur_r;
  bit [3:0]    cur_v;
  bit          cur_g;

  // Reference model state per instance: 0 = rr4, 1 = fixed4, 2 = rr3
  int          mn    [3];
  bit          mrr   [3];
  bit          m_lk  [3];
  int          m_li  [3];
  int          m_ptr [3];
  bit          prev_lk  [3];
  logic [31:0] prev_dat [3];

  typedef struct {
    bit       r;
    bit [3:0] v;
    bit       g;
    int       sel;
    bit       ov;
    bit [3:0] gr;
    bit       lk;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit [3:0] v, input bit g,
                            output int esel, output bit eov, output bit [3:0] egr, output bit elk);
    int n;
    int start;
    int idx;
    n = mn[k];
    esel = 0; eov = 1'b0; egr = '0; elk = 1'b0;
    if (!r) begin
      m_lk[k] = 1'b0; m_li[k] = 0; m_ptr[k] = 0;
    end else if (m_lk[k]) begin
      esel = m_li[k];
      eov  = v[esel[1:0]];
      elk  = 1'b1;
      if (eov && g) begin
        egr = 4'(1 << esel);
        m_lk[k] = 1'b0;
        if (mrr[k]) m_ptr[k] = (esel + 1) % n;
      end else if (!eov) begin
        m_lk[k] = 1'b0;
      end
    end else begin
      start = mrr[k] ? m_ptr[k] : 0;
      esel  = start;
      for (int off = 0; off < n; off++) begin
        idx = (start + off) % n;
        if (v[idx[1:0]]) begin
          esel = idx; eov = 1'b1;
          break;
        end
      end
      if (eov && g) begin
        egr = 4'(1 << esel);
        if (mrr[k]) m_ptr[k] = (esel + 1) % n;
      end else if (eov) begin
        m_lk[k] = 1'b1; m_li[k] = esel;
      end
    end
  endtask

  task automatic check_one(input int k, input string tag, input logic [3:0] sel, input logic ov,
                           input logic [3:0] gr, input logic lk, input logic [31:0] dat);
    int       es;
    bit       eo;
    bit [3:0] eg;
    bit       el;
    bit [3:0] v;
    v = (k == 2) ? (cur_v & 4'b0111) : cur_v;
    model_step(k, cur_r, v, cur_g, es, eo, eg, el);
    chk({tag, ".sel"},       64'(sel), 64'(es));
    chk({tag, ".out_valid"}, 64'(ov),  64'(eo));
    chk({tag, ".in_grant"},  64'(gr),  64'(eg));
    chk({tag, ".locked"},    64'(lk),  64'(el));
    chk({tag, ".out_data"},  64'(dat), 64'(d[es[1:0]]));
    chk({tag, ".grant_onehot0"}, 64'($countones(gr) <= 1), 64'(1));
    if (prev_lk[k] && lk) chk({tag, ".data_stable"}, 64'(dat), 64'(prev_dat[k]));
    prev_lk[k]  = lk;
    prev_dat[k] = dat;
  endtask

  task automatic cycle(input bit r, input bit [3:0] v, input bit g);
    @(posedge clk);
    #1;
    cur_r = r; cur_v = v; cur_g = g;
    rstn = r;
    bus4.in_valid = v;  busf.in_valid = v;  bus3.in_valid = v[2:0];
    bus4.out_grant = g; busf.out_grant = g; bus3.out_grant = g;
    bus4.in_data = {d[3], d[2], d[1], d[0]};
    busf.in_data = {d[3], d[2], d[1], d[0]};
    bus3.in_data = {d[2], d[1], d[0]};
    #4;
    check_one(0, "rr4", 4'(bus4.sel), bus4.out_valid, bus4.in_grant, bus4.locked, bus4.out_data);
    check_one(1, "fix", 4'(busf.sel), busf.out_valid, busf.in_grant, busf.locked, busf.out_data);
    check_one(2, "rr3", 4'(bus3.sel), bus3.out_valid, 4'(bus3.in_grant), bus3.locked, bus3.out_data);
  endtask

  function automatic vec_t mk(input bit r, input bit [3:0] v, input bit g, input int sel,
                              input bit ov, input bit [3:0] gr, input bit lk);
    vec_t x;
    x.r = r; x.v = v; x.g = g; x.sel = sel; x.ov = ov; x.gr = gr; x.lk = lk;
    return x;
  endfunction

  initial begin
    bit       r;
    bit [3:0] v;
    bit       g;

    rstn = 1'b0;
    bus4.in_valid = '0; busf.in_valid = '0; bus3.in_valid = '0;
    bus4.out_grant = 1'b0; busf.out_grant = 1'b0; bus3.out_grant = 1'b0;
    bus4.in_data = '0; busf.in_data = '0; bus3.in_data = '0;
    for (int i = 0; i < 4; i++) d[i] = 32'hD00D_0000 + 32'(i * 32'h1111);
    mn  = '{4, 4, 3};
    mrr = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      m_lk[k] = 1'b0; m_li[k] = 0; m_ptr[k] = 0; prev_lk[k] = 1'b0; prev_dat[k] = '0;
    end

    // Hand-derived expectations for the 4-input round-robin instance
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 1, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 2, 1, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 3, 1, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 1, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 2, 1, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 3, 1, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 1, 4'b0000, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'b0011, 0, 1, 1, 4'b0000, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 1, 1, 4'b0010, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 0, 1, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 4'b0000, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 3, 0, 4'b0000, 1));
    tbl.push_back(mk(1, 4'b1111, 1, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 2, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 1, 4'b0001, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].g);
      chk($sformatf("tbl[%0d].sel", i),       64'(bus4.sel),       64'(tbl[i].sel));
      chk($sformatf("tbl[%0d].out_valid", i), 64'(bus4.out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl[%0d].in_grant", i),  64'(bus4.in_grant),  64'(tbl[i].gr));
      chk($sformatf("tbl[%0d].locked", i),    64'(bus4.locked),    64'(tbl[i].lk));
    end

    // Fixed priority ignores fairness: index 1 wins every cycle
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'b1110, 1);
      chk("fixed.in_grant", 64'(busf.in_grant), 64'(4'b0010));
      chk("fixed.sel",      64'(busf.sel),      64'(1));
    end

    // Three-input wrap: pointer goes from 2 back to 0
    cycle(0, 4'b0000, 0);
    cycle(1, 4'b0100, 1);
    chk("wrap3.sel0",   64'(bus3.sel),      64'(2));
    chk("wrap3.grant0", 64'(bus3.in_grant), 64'(3'b100));
    cycle(1, 4'b0111, 1);
    chk("wrap3.sel1",   64'(bus3.sel),      64'(0));
    chk("wrap3.grant1", 64'(bus3.in_grant), 64'(3'b001));
    cycle(1, 4'b0111, 1);
    chk("wrap3.grant2", 64'(bus3.in_grant), 64'(3'b010));
    cycle(1, 4'b0111, 1);
    chk("wrap3.grant3", 64'(bus3.in_grant), 64'(3'b100));
    cycle(1, 4'b0111, 1);
    chk("wrap3.grant4", 64'(bus3.in_grant), 64'(3'b001));

    // Random traffic with sticky requests so locks persist across cycles
    v = 4'($urandom);
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 39) != 0);
      if (!r) for (int j = 0; j < 4; j++) d[j] = $urandom;
      if ($urandom_range(0, 3) == 0) v = 4'($urandom);
      g = ($urandom_range(0, 2) == 0);
      cycle(r, v, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
